// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: opcodes, packet field offsets,
// motor commands, flag bit positions and controller states.
package ex_stage_pkg;

  localparam logic [4:0] OpMov       = 5'd0;
  localparam logic [4:0] OpAdd       = 5'd1;
  localparam logic [4:0] OpSub       = 5'd2;
  localparam logic [4:0] OpAnd       = 5'd3;
  localparam logic [4:0] OpOr        = 5'd4;
  localparam logic [4:0] OpNot       = 5'd5;
  localparam logic [4:0] OpCmp       = 5'd6;
  localparam logic [4:0] OpMult      = 5'd7;
  localparam logic [4:0] OpDiv       = 5'd8;
  localparam logic [4:0] OpObCheck   = 5'd9;
  localparam logic [4:0] OpVelGuard  = 5'd10;
  localparam logic [4:0] OpMoveLeft  = 5'd11;
  localparam logic [4:0] OpMoveRight = 5'd12;
  localparam logic [4:0] OpStop      = 5'd13;
  localparam logic [4:0] OpContinue  = 5'd14;

  // Field offsets inside in_data; operand B sits directly above operand A.
  localparam int unsigned RdLsb = 0;
  localparam int unsigned OpLsb = 4;
  localparam int unsigned ALsb  = 9;

  localparam logic [1:0] MotorStop  = 2'd0;
  localparam logic [1:0] MotorLeft  = 2'd1;
  localparam logic [1:0] MotorRight = 2'd2;

  localparam int unsigned FlagDz = 0;
  localparam int unsigned FlagC  = 1;
  localparam int unsigned FlagN  = 2;
  localparam int unsigned FlagZ  = 3;

  typedef enum logic [1:0] {StIdle, StExec, StMd, StOut} state_e;

endpackage

// File: rtl/ex_stage_muldiv.sv
// Iterative unsigned shift-add multiplier and restoring divider, one bit per cycle.
// done_o and result_o are valid combinationally during the final iteration.
module ex_muldiv #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             done_o,
  output logic [Width-1:0] result_o,
  output logic             hi_nz_o
);
  localparam int unsigned CntW = $clog2(Width);

  logic                 busy_q, is_div_q;
  logic [CntW-1:0]      cnt_q;
  logic [2*Width-1:0]   prod_q, prod_d, mcand_q;
  logic [Width-1:0]     mplier_q, divisor_q, quo_q, quo_d, rem_q, rem_d;
  logic [Width:0]       rem_shift, trial;

  always_comb begin
    prod_d    = prod_q + (mplier_q[0] ? mcand_q : '0);
    rem_shift = {rem_q, quo_q[Width-1]};
    trial     = rem_shift - {1'b0, divisor_q};
    // Negative trial leaves the remainder untouched (restoring step).
    rem_d     = trial[Width] ? rem_shift[Width-1:0] : trial[Width-1:0];
    quo_d     = {quo_q[Width-2:0], ~trial[Width]};
  end

  assign done_o   = busy_q && (cnt_q == CntW'(Width - 1));
  assign result_o = is_div_q ? quo_d : prod_d[Width-1:0];
  assign hi_nz_o  = |prod_d[2*Width-1:Width];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q    <= 1'b0;
      is_div_q  <= 1'b0;
      cnt_q     <= '0;
      prod_q    <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      divisor_q <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
    end else if (start_i) begin
      busy_q    <= 1'b1;
      is_div_q  <= is_div_i;
      cnt_q     <= '0;
      prod_q    <= '0;
      mcand_q   <= {{Width{1'b0}}, a_i};
      mplier_q  <= b_i;
      divisor_q <= b_i;
      quo_q     <= a_i;
      rem_q     <= '0;
    end else if (busy_q) begin
      cnt_q    <= cnt_q + CntW'(1);
      prod_q   <= prod_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: captures a decoded packet over req/ack, runs ALU, mul/div or
// motor-control ops, and hands a write-back packet to WB over a second req/ack.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned DataWidth = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_req,
  input  logic [2*DataWidth+9:0] in_data,
  output logic                   in_ack,
  output logic                   out_req,
  input  logic                   out_ack,
  output logic [DataWidth-1:0]   wb_data,
  output logic [3:0]             wb_reg_addr,
  output logic                   wb_reg_write,
  output logic [3:0]             flags,
  output logic [1:0]             motor_cmd
);
  localparam int unsigned BLsb = ALsb + DataWidth;

  state_e               state_q, state_d;
  logic [DataWidth-1:0] a_q, a_d, b_q, b_d;
  logic [4:0]           op_q, op_d;
  logic [3:0]           rd_q, rd_d;
  logic                 in_ack_q, in_ack_d, out_req_q, out_req_d;
  logic [DataWidth-1:0] wb_data_q, wb_data_d;
  logic [3:0]           wb_addr_q, wb_addr_d;
  logic                 wb_we_q, wb_we_d;
  logic [3:0]           flags_q, flags_d;
  logic [1:0]           motor_q, motor_d;

  logic                 md_start, md_done, md_hi_nz;
  logic [DataWidth-1:0] md_result, res, zn_src;
  logic [DataWidth:0]   sum, diff;
  logic                 res_we, zn_upd;
  logic                 unused_in;

  assign unused_in = in_data[2*DataWidth+9];
  assign sum       = {1'b0, a_q} + {1'b0, b_q};
  assign diff      = {1'b0, a_q} - {1'b0, b_q};
  // Divide by zero resolves in EXEC without touching the iterative unit.
  assign md_start  = (state_q == StExec) &&
                     ((op_q == OpMult) || ((op_q == OpDiv) && (b_q != '0)));

  ex_muldiv #(
    .Width(DataWidth)
  ) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start_i  (md_start),
    .is_div_i (op_q == OpDiv),
    .a_i      (a_q),
    .b_i      (b_q),
    .done_o   (md_done),
    .result_o (md_result),
    .hi_nz_o  (md_hi_nz)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_req && !in_ack_q) state_d = StExec;
      StExec:  state_d = md_start ? StMd : StOut;
      StMd:    if (md_done) state_d = StOut;
      StOut:   if (out_ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    rd_d      = rd_q;
    in_ack_d  = 1'b0;
    out_req_d = out_req_q;
    wb_data_d = wb_data_q;
    wb_addr_d = wb_addr_q;
    wb_we_d   = wb_we_q;
    flags_d   = flags_q;
    motor_d   = motor_q;
    res       = '0;
    res_we    = 1'b0;
    zn_upd    = 1'b0;
    zn_src    = '0;
    unique case (state_q)
      StIdle: begin
        if (in_req && !in_ack_q) begin
          in_ack_d = 1'b1;
          a_d      = in_data[ALsb +: DataWidth];
          b_d      = in_data[BLsb +: DataWidth];
          op_d     = in_data[OpLsb +: 5];
          rd_d     = in_data[RdLsb +: 4];
        end
      end
      StExec: begin
        wb_addr_d = rd_q;
        wb_we_d   = 1'b0;
        out_req_d = !md_start;
        case (op_q)
          OpMov:       begin res = a_q;                 res_we = 1'b1; end
          OpAnd:       begin res = a_q & b_q;           res_we = 1'b1; end
          OpOr:        begin res = a_q | b_q;           res_we = 1'b1; end
          OpNot:       begin res = ~a_q;                res_we = 1'b1; end
          OpVelGuard:  begin res = (a_q < b_q) ? a_q : b_q; res_we = 1'b1; end
          OpObCheck: begin
            res    = (a_q < b_q) ? DataWidth'(1) : '0;
            res_we = 1'b1;
          end
          OpAdd: begin
            res            = sum[DataWidth-1:0];
            res_we         = 1'b1;
            flags_d[FlagC] = sum[DataWidth];
          end
          OpSub: begin
            res            = diff[DataWidth-1:0];
            res_we         = 1'b1;
            flags_d[FlagC] = diff[DataWidth];
          end
          OpCmp: begin
            zn_upd         = 1'b1;
            zn_src         = diff[DataWidth-1:0];
            flags_d[FlagC] = diff[DataWidth];
          end
          OpDiv: begin
            if (b_q == '0) begin
              res             = '1;
              res_we          = 1'b1;
              flags_d[FlagDz] = 1'b1;
            end
          end
          OpMoveLeft:  motor_d = MotorLeft;
          OpMoveRight: motor_d = MotorRight;
          OpStop:      motor_d = MotorStop;
          default:     ;
        endcase
      end
      StMd: begin
        if (md_done) begin
          res       = md_result;
          res_we    = 1'b1;
          out_req_d = 1'b1;
          if (op_q == OpMult) flags_d[FlagC]  = md_hi_nz;
          else                flags_d[FlagDz] = 1'b0;
        end
      end
      StOut:   if (out_ack) out_req_d = 1'b0;
      default: ;
    endcase
    if (res_we) begin
      wb_data_d = res;
      wb_we_d   = 1'b1;
      zn_upd    = 1'b1;
      zn_src    = res;
    end
    if (zn_upd) begin
      flags_d[FlagZ] = (zn_src == '0);
      flags_d[FlagN] = zn_src[DataWidth-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      in_ack_q  <= 1'b0;
      out_req_q <= 1'b0;
      wb_data_q <= '0;
      wb_addr_q <= '0;
      wb_we_q   <= 1'b0;
      flags_q   <= '0;
      motor_q   <= MotorStop;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      in_ack_q  <= in_ack_d;
      out_req_q <= out_req_d;
      wb_data_q <= wb_data_d;
      wb_addr_q <= wb_addr_d;
      wb_we_q   <= wb_we_d;
      flags_q   <= flags_d;
      motor_q   <= motor_d;
    end
  end

  assign in_ack       = in_ack_q;
  assign out_req      = out_req_q;
  assign wb_data      = wb_data_q;
  assign wb_reg_addr  = wb_addr_q;
  assign wb_reg_write = wb_we_q;
  assign flags        = flags_q;
  assign motor_cmd    = motor_q;

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the asynchronous-style CPU pipeline, directly downstream of instruction decode. Accepts one decoded packet (operand B, operand A, opcode, destination register) per four-phase req/ack transaction, performs the ALU, multiply/divide or robot-control operation, and presents a write-back packet to the WB stage over a second req/ack handshake. Multiply and divide are iterative, so the stage is the pipeline's variable-latency point.

## Interface
- `DataWidth`, 16: operand/result width; MULT/DIV iteration count equals this.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `in_req` in 1: decode packet valid, held until `in_ack` seen.
- `in_data` in 42: `[40:25]` B, `[24:9]` A, `[8:4]` opcode, `[3:0]` rd; bit 41 ignored.
- `in_ack` out 1: one-cycle pulse, packet captured.
- `out_req` out 1: write-back packet valid; level, held until `out_ack`.
- `out_ack` in 1: WB accepted packet.
- `wb_data` out 16, `wb_reg_addr` out 4, `wb_reg_write` out 1: write-back packet, stable while `out_req`=1.
- `flags` out 4: {Z,N,C,DZ}, registered.
- `motor_cmd` out 2: registered drive command; STOP after reset.

## Operation
- FSM: IDLE → EXEC → (MD) → OUT → IDLE.
- IDLE: `in_req`=1 and `in_ack`=0 → latch `in_data`, `in_ack`<=1 for exactly one cycle, go EXEC.
- EXEC: single-cycle ops compute result into output registers, go OUT; MULT/DIV load `ex_muldiv`, go MD.
- MD: wait for `ex_muldiv` done, then OUT.
- OUT: `out_req`=1; on `out_ack`=1 sampled, `out_req`<=0, go IDLE.
- MOV: A. ADD/SUB: A±B mod 2^16, C = carry out / borrow. AND/OR: bitwise. NOT: ~A.
- CMP: flags from A−B only, `wb_reg_write`=0.
- MULT: low 16 bits of unsigned A×B; C=1 if high half nonzero.
- DIV: unsigned A/B quotient; B=0 → result 16'hFFFF, DZ=1, no iteration (MD skipped).
- OB_CHECK: result = (A < B) ? 1 : 0. VELOCITY_GUARD: result = min(A,B) unsigned. Both write rd.
- MOVE_LEFT/RIGHT/STOP/CONTINUE: update `motor_cmd` in EXEC, `wb_reg_write`=0. CONTINUE leaves `motor_cmd` unchanged.
- Z/N updated by every result-producing op and CMP; C/DZ only by their ops; control ops leave flags unchanged.
- Unknown opcode: complete transaction with `wb_reg_write`=0, flags unchanged (no pipeline hang).
- `wb_reg_addr` = rd for every packet.

## Timing
- Reset: state IDLE, `in_ack`=0, `out_req`=0, `wb_data`=0, `wb_reg_addr`=0, `wb_reg_write`=0, `flags`=0, `motor_cmd`=STOP.
- Capture at edge k → `in_ack` high k..k+1; single-cycle op → `out_req` high after edge k+1.
- MULT/DIV (B≠0): `out_req` high after edge k+1+DataWidth (k+17).
- `in_req` held high across the ack cycle is not re-captured; new capture only from IDLE.
- `out_ack` already high on entry to OUT: handshake completes at the next edge (one-cycle `out_req`).
- `out_ack` outside OUT: ignored. `in_req` outside IDLE: not acknowledged (back-pressure).
- Reset mid-transaction: packet discarded, outputs to reset values immediately.

## Structure
- `defines.v`: OP_* opcodes, in_data field positions, MOTOR_* encodings, flag bit indices.
- Sub-module `ex_muldiv`: shift-add multiplier and restoring divider, start/done, one bit per cycle.

## Test plan
- ADD A=16'h7FFF B=1 rd=3 → `out_req` after k+1, `wb_data`=16'h8000, addr 3, write=1, N=1 C=0.
- SUB A=5 B=5 then CMP A=3 B=7 → first result 0 Z=1; CMP `wb_reg_write`=0, C=1.
- MULT A=300 B=300 → 16'h5F90, C=1, `out_req` exactly 17 cycles after capture; DIV 100/7 → 14.
- DIV A=9 B=0 → 16'hFFFF, DZ=1, latency as single-cycle op.
- MOVE_LEFT, CONTINUE, OB_CHECK A=10 B=20 → `motor_cmd` LEFT twice, no writes, then `wb_data`=1.
- `out_ack` held low 10 cycles with `in_req` high → packet stable, no second `in_ack`; assert `reset` mid-MD → all outputs reset.
